// File: rtl/aurora_tx_sel.sv
// aurora_tx_sel: frame-atomic TX source selector (user / loopback / pattern / idle).
// Pattern generator is built only when AURORA_TXSEL_PATTERN_EN is defined.
module aurora_tx_sel #(
    parameter int DATA_WIDTH = 32,
    parameter int LOOP_DEPTH = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int PAT_LEN    = 8
) (
    input  logic                  user_clk,
    input  logic                  reset,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m_axis_tx_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tx_tdata,
    output logic                  m_axis_tx_tlast,
    input  logic                  m_axis_tx_tready,
    input  logic                  s_axis_rx_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_rx_tdata,
    input  logic                  s_axis_rx_tlast,
    input  logic                  reg_wr_en,
    input  logic                  reg_rd_en,
    input  logic [2:0]            reg_addr,
    input  logic [31:0]           reg_wdata,
    output logic [31:0]           reg_rdata,
    output logic                  reg_rvalid
);
    localparam int AW = $clog2(LOOP_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(LOOP_DEPTH);

    typedef enum logic [1:0] {
        MODE_USER = 2'd0,
        MODE_LOOP = 2'd1,
        MODE_PAT  = 2'd2,
        MODE_IDLE = 2'd3
    } mode_e;

    function automatic mode_e map_mode(input logic [1:0] m);
`ifdef AURORA_TXSEL_PATTERN_EN
        map_mode = mode_e'(m);
`else
        map_mode = (m == 2'd2) ? MODE_IDLE : mode_e'(m);
`endif
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] c,
        input logic                 en
    );
        sat_inc = (en && (c != '1)) ? c + CNT_WIDTH'(1) : c;
    endfunction

    function automatic logic [31:0] zext(input logic [CNT_WIDTH-1:0] v);
        zext = '0;
        zext[CNT_WIDTH-1:0] = v;
    endfunction

    mode_e                 req_mode_q, req_mode_d;
    mode_e                 act_mode_q, act_mode_d;
    logic                  tx_in_frame_q, tx_in_frame_d;
    logic                  rx_aligned_q, rx_aligned_d;
    logic                  loop_ovf_q, loop_ovf_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           fifo_cnt_q, fifo_cnt_d;
    logic [CNT_WIDTH-1:0]  tx_frames_q, tx_frames_d;
    logic [CNT_WIDTH-1:0]  rx_frames_q, rx_frames_d;
    logic [CNT_WIDTH-1:0]  loop_drops_q, loop_drops_d;
    logic [31:0]           reg_rdata_q, reg_rdata_d;
    logic                  reg_rvalid_q;
    logic [DATA_WIDTH:0]   mem_q [LOOP_DEPTH];

    logic                  tx_valid, tx_last, tx_fire;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  fifo_empty, fifo_full;
    logic                  loop_wr_req, loop_wr, loop_rd, loop_drop;
    logic                  ctrl_wr, cnt_clr;
    logic                  unused_ok;

    assign unused_ok = ^{reg_wdata[31:3], 1'b0};

    assign fifo_empty  = (fifo_cnt_q == '0);
    assign fifo_full   = (fifo_cnt_q == FULL_CNT);
    assign tx_fire     = tx_valid & m_axis_tx_tready;
    assign loop_rd     = (act_mode_q == MODE_LOOP) & tx_fire;
    assign loop_wr_req = (act_mode_q == MODE_LOOP) & rx_aligned_q
                       & s_axis_rx_tvalid;
    // A full FIFO still takes a write when a read frees a slot this cycle.
    assign loop_wr     = loop_wr_req & (~fifo_full | loop_rd);
    assign loop_drop   = loop_wr_req & fifo_full & ~loop_rd;
    assign ctrl_wr     = reg_wr_en & (reg_addr == 3'd0);
    assign cnt_clr     = ctrl_wr & reg_wdata[2];

`ifdef AURORA_TXSEL_PATTERN_EN
    localparam int PW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

    logic [DATA_WIDTH-1:0] pat_cnt_q, pat_cnt_d;
    logic [PW-1:0]         pat_idx_q, pat_idx_d;
    logic                  pat_last;

    assign pat_last = (pat_idx_q == PW'(PAT_LEN - 1));

    always_comb begin
        pat_cnt_d = pat_cnt_q;
        pat_idx_d = pat_idx_q;
        if ((act_mode_q == MODE_PAT) && tx_fire) begin
            pat_cnt_d = pat_cnt_q + DATA_WIDTH'(1);
            pat_idx_d = pat_last ? '0 : pat_idx_q + PW'(1);
        end
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            pat_cnt_q <= '0;
            pat_idx_q <= '0;
        end else begin
            pat_cnt_q <= pat_cnt_d;
            pat_idx_q <= pat_idx_d;
        end
    end
`else
    localparam int unused_pat_len = PAT_LEN;
`endif

    // TX source mux driven by the registered active mode.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_last  = 1'b0;
        unique case (act_mode_q)
            MODE_USER: begin
                tx_valid = s_axis_tvalid;
                tx_data  = s_axis_tdata;
                tx_last  = s_axis_tlast;
            end
            MODE_LOOP: begin
                tx_valid = ~fifo_empty;
                if (!fifo_empty) begin
                    {tx_last, tx_data} = mem_q[rd_ptr_q];
                end
            end
`ifdef AURORA_TXSEL_PATTERN_EN
            MODE_PAT: begin
                tx_valid = 1'b1;
                tx_data  = pat_cnt_q;
                tx_last  = pat_last;
            end
`endif
            default: begin
                tx_valid = 1'b0;
            end
        endcase
    end

    assign m_axis_tx_tvalid = tx_valid;
    assign m_axis_tx_tdata  = tx_data;
    assign m_axis_tx_tlast  = tx_last;
    assign s_axis_tready    = (act_mode_q == MODE_USER) & m_axis_tx_tready;

    always_comb begin
        req_mode_d    = req_mode_q;
        act_mode_d    = act_mode_q;
        tx_in_frame_d = tx_in_frame_q;
        rx_aligned_d  = rx_aligned_q;
        loop_ovf_d    = loop_ovf_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;

        if (ctrl_wr) begin
            req_mode_d = map_mode(reg_wdata[1:0]);
        end
        // Switch only on a frame boundary with no beat in flight.
        if (!tx_in_frame_q && !tx_fire) begin
            act_mode_d = req_mode_d;
        end
        if (tx_fire) begin
            tx_in_frame_d = ~tx_last;
        end
        if ((act_mode_q == MODE_LOOP) && s_axis_rx_tvalid && s_axis_rx_tlast) begin
            rx_aligned_d = 1'b1;
        end
        if (loop_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (loop_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (loop_wr && !loop_rd) begin
            fifo_cnt_d = fifo_cnt_q + (AW+1)'(1);
        end else if (!loop_wr && loop_rd) begin
            fifo_cnt_d = fifo_cnt_q - (AW+1)'(1);
        end
        if (loop_drop) begin
            loop_ovf_d = 1'b1;
        end
        if ((act_mode_q == MODE_LOOP) && (act_mode_d != MODE_LOOP)) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_cnt_d   = '0;
            rx_aligned_d = 1'b0;
        end

        tx_frames_d  = sat_inc(tx_frames_q, tx_fire & tx_last);
        rx_frames_d  = sat_inc(rx_frames_q, s_axis_rx_tvalid & s_axis_rx_tlast);
        loop_drops_d = sat_inc(loop_drops_q, loop_drop);
        if (cnt_clr) begin
            tx_frames_d  = '0;
            rx_frames_d  = '0;
            loop_drops_d = '0;
            loop_ovf_d   = 1'b0;
        end
    end

    always_comb begin
        reg_rdata_d = '0;
        if (reg_rd_en) begin
            unique case (reg_addr)
                3'd0:    reg_rdata_d[1:0] = req_mode_q;
                3'd1:    reg_rdata_d[4:0] = {fifo_empty, tx_in_frame_q,
                                             loop_ovf_q, act_mode_q};
                3'd2:    reg_rdata_d = zext(tx_frames_q);
                3'd3:    reg_rdata_d = zext(rx_frames_q);
                3'd4:    reg_rdata_d = zext(loop_drops_q);
                default: reg_rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            req_mode_q    <= MODE_IDLE;
            act_mode_q    <= MODE_IDLE;
            tx_in_frame_q <= 1'b0;
            rx_aligned_q  <= 1'b0;
            loop_ovf_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            tx_frames_q   <= '0;
            rx_frames_q   <= '0;
            loop_drops_q  <= '0;
            reg_rdata_q   <= '0;
            reg_rvalid_q  <= 1'b0;
        end else begin
            req_mode_q    <= req_mode_d;
            act_mode_q    <= act_mode_d;
            tx_in_frame_q <= tx_in_frame_d;
            rx_aligned_q  <= rx_aligned_d;
            loop_ovf_q    <= loop_ovf_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            tx_frames_q   <= tx_frames_d;
            rx_frames_q   <= rx_frames_d;
            loop_drops_q  <= loop_drops_d;
            reg_rdata_q   <= reg_rdata_d;
            reg_rvalid_q  <= reg_rd_en;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge user_clk) begin
        if (loop_wr) begin
            mem_q[wr_ptr_q] <= {s_axis_rx_tlast, s_axis_rx_tdata};
        end
    end

    assign reg_rdata  = reg_rdata_q;
    assign reg_rvalid = reg_rvalid_q;

endmodule
